wm_cycle_controller: RTL
========================

Name: wm_cycle_controller

Overview:
- Parametrised washing-machine sequencer, the successor to the fixed 3-mode controller FSM.
- Accumulates coin credit up to a configurable price and takes one of three wash programmes.
- Times each phase with a down-counter, pauses while the lid is open, drives water intake, and refunds credit coin-by-coin on cancel.
- Sits between the front-panel inputs and the motor/valve drivers.

Parameters:
- SOAK_CYCLES, 8: soak phase duration in lid-closed clock cycles (>=2).
- WASH_CYCLES, 12: wash phase duration (>=2).
- RINSE_CYCLES, 6: rinse phase duration (>=2).
- SPIN_CYCLES, 4: spin phase duration (>=1).
- FILL_CYCLES, 2: water-intake cycles at the start of each soak/wash/rinse phase; must be less than each of those durations.
- CNT_W, 8: phase timer width; must hold max duration-1.
- COIN_PRICE, 2: coins required to reach READY (>=1).
- COIN_W, 4: credit counter width; must hold COIN_PRICE.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- lid  in  1  1 = lid open.
- coin  in  1  one-cycle pulse per inserted coin.
- cancel  in  1  level; sampled each cycle.
- mode_1  in  1  programme 1: soak, wash, rinse, spin.
- mode_2  in  1  programme 2: wash, rinse, spin.
- mode_3  in  1  programme 3: rinse, spin.
- idle  out  1  in IDLE.
- ready  out  1  in READY.
- soak_Operation  out  1  in SOAK.
- wash_Operation  out  1  in WASH.
- rinse_Operation  out  1  in RINSE.
- spin_Operation  out  1  in SPIN.
- water_Intake  out  1  valve open.
- coin_Return  out  1  one-cycle pulse per refunded coin.
- done  out  1  one-cycle pulse when a programme completes.
- credit  out  COIN_W  current coin credit.

Behaviour:
- All outputs are registered.
- Reset clears all outputs and credit to 0, forces IDLE, and sets idle=1. Reset mid-cycle or mid-refund: immediate IDLE, no refund, credit lost.
- States: IDLE, READY, SOAK, WASH, RINSE, SPIN, REFUND. State outputs are one-hot and registered, valid the cycle after entry.
- IDLE:
  - coin increments credit.
  - When credit+coin reaches COIN_PRICE, go to READY next cycle.
  - cancel with credit>0 goes to REFUND; cancel has priority over a coincident coin, and that coin is returned too (credit+1 refunded).
- READY:
  - An extra coin produces a coin_Return pulse the next cycle; credit unchanged.
  - cancel goes to REFUND.
  - Otherwise, if lid=0 and any mode bit is set, start. Priority mode_1 > mode_2 > mode_3.
  - On start, credit is cleared and the programme is latched. Mode bits are ignored after start.
- Phase timer:
  - Loaded with DUR-1 on phase entry.
  - Decrements only in cycles with lid=0.
  - In a cycle with timer==0 and lid=0, advance to the next phase. Each phase lasts exactly DUR lid-closed cycles.
  - With lid=1, the timer and state freeze and the phase output stays high.
- water_Intake=1 during the first FILL_CYCLES lid-closed cycles of SOAK/WASH/RINSE, forced 0 while lid=1, and always 0 in SPIN.
- Sequence is SOAK → WASH → RINSE → SPIN, entering at the programme's first phase.
- SPIN completion: done pulses for 1 cycle and the FSM returns to IDLE.
- cancel in SOAK/WASH/RINSE jumps to SPIN next cycle with a full SPIN_CYCLES and no refund. cancel during SPIN is ignored.
- coin outside IDLE/READY is ignored.
- REFUND:
  - coin_Return pulses high every other cycle, first pulse on the cycle after entry.
  - credit decrements with each pulse.
  - Exit to IDLE after credit reaches 0.
  - coin and cancel are ignored while in REFUND.

Optional Feature:
- Macro DOUBLE_RINSE_EN.
- Defined: RINSE executes twice back-to-back for every programme, with the timer reloaded for the second pass and FILL_CYCLES of water intake repeated. rinse_Operation stays high continuously across both passes. cancel in either pass goes to SPIN.
- Undefined: single rinse pass, exactly as described in Behaviour.

Test Plan (default parameters):
- Two coin pulses 3 cycles apart, then mode_2 pulse with lid=0 → ready high 1 cycle after 2nd coin; wash 12 cycles with water_Intake high for first 2; rinse 6; spin 4; done single pulse; idle thereafter; credit=0.
- mode_1 run with lid=1 for 5 cycles mid-WASH → wash_Operation stays high 12+5 cycles total; timer frozen; water_Intake 0 while lid open.
- 2 coins, then cancel in READY → coin_Return pulses exactly twice, 2 cycles apart; credit 2→1→0; then idle.
- mode_3 started, cancel asserted 2 cycles into RINSE → spin_Operation next cycle for 4 cycles, done pulse, no coin_Return.
- Third coin in READY → one coin_Return pulse, credit stays 2. Reset asserted mid-SOAK → idle=1 next cycle, all others 0.
- DOUBLE_RINSE_EN defined, mode_3 → rinse_Operation high 12 cycles with water_Intake high cycles 1-2 and 7-8; then spin 4.

Source files
------------

// File: rtl/wm_cycle_controller.sv
// Coin-operated washing-machine sequencer: credit, programme phases, refund.
// Optional DOUBLE_RINSE_EN repeats the rinse phase with a fresh fill.
module wm_cycle_controller #(
  parameter int SOAK_CYCLES  = 8,
  parameter int WASH_CYCLES  = 12,
  parameter int RINSE_CYCLES = 6,
  parameter int SPIN_CYCLES  = 4,
  parameter int FILL_CYCLES  = 2,
  parameter int CNT_W        = 8,
  parameter int COIN_PRICE   = 2,
  parameter int COIN_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lid,
  input  logic              coin,
  input  logic              cancel,
  input  logic              mode_1,
  input  logic              mode_2,
  input  logic              mode_3,
  output logic              idle,
  output logic              ready,
  output logic              soak_Operation,
  output logic              wash_Operation,
  output logic              rinse_Operation,
  output logic              spin_Operation,
  output logic              water_Intake,
  output logic              coin_Return,
  output logic              done,
  output logic [COIN_W-1:0] credit
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_SOAK,
    S_WASH,
    S_RINSE,
    S_SPIN,
    S_REFUND
  } state_t;

  localparam logic [CNT_W-1:0] SOAK_LD  = CNT_W'(SOAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOAK_TH  = CNT_W'(SOAK_CYCLES - FILL_CYCLES);
  localparam logic [CNT_W-1:0] WASH_TH  = CNT_W'(WASH_CYCLES - FILL_CYCLES);
  localparam logic [CNT_W-1:0] RINSE_TH = CNT_W'(RINSE_CYCLES - FILL_CYCLES);
  localparam logic [COIN_W-1:0] PRICE   = COIN_W'(COIN_PRICE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [COIN_W-1:0]  credit_q, credit_d;
  logic               ph_q, ph_d;
  logic               ret_d, done_d, water_d;
  logic [COIN_W-1:0]  credit_inc;
  logic [COIN_W-1:0]  refund_amt;
`ifdef DOUBLE_RINSE_EN
  logic               pass2_q, pass2_d;
`endif

  assign credit_inc = credit_q + COIN_W'(1);
  assign refund_amt = credit_q + {{(COIN_W-1){1'b0}}, coin};
  assign credit     = credit_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    credit_d = credit_q;
    ph_d     = ph_q;
    ret_d    = 1'b0;
    done_d   = 1'b0;
`ifdef DOUBLE_RINSE_EN
    pass2_d  = pass2_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // cancel wins over a same-cycle coin, which is refunded as well
        if (cancel) begin
          if (refund_amt != '0) begin
            state_d  = S_REFUND;
            credit_d = refund_amt - COIN_W'(1);
            ret_d    = 1'b1;
            ph_d     = 1'b1;
          end
        end else if (coin) begin
          credit_d = credit_inc;
          if (credit_inc >= PRICE) state_d = S_READY;
        end
      end
      S_READY: begin
        if (cancel) begin
          state_d  = S_REFUND;
          credit_d = refund_amt - COIN_W'(1);
          ret_d    = 1'b1;
          ph_d     = 1'b1;
        end else begin
          ret_d = coin;
          if (!lid && (mode_1 || mode_2 || mode_3)) begin
            credit_d = '0;
`ifdef DOUBLE_RINSE_EN
            pass2_d  = 1'b0;
`endif
            if (mode_1) begin
              state_d = S_SOAK;
              timer_d = SOAK_LD;
            end else if (mode_2) begin
              state_d = S_WASH;
              timer_d = WASH_LD;
            end else begin
              state_d = S_RINSE;
              timer_d = RINSE_LD;
            end
          end
        end
      end
      S_SOAK, S_WASH, S_RINSE: begin
        if (!lid) begin
          if (cancel) begin
            state_d = S_SPIN;
            timer_d = SPIN_LD;
          end else if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
          end else if (state_q == S_SOAK) begin
            state_d = S_WASH;
            timer_d = WASH_LD;
          end else if (state_q == S_WASH) begin
            state_d = S_RINSE;
            timer_d = RINSE_LD;
`ifdef DOUBLE_RINSE_EN
            pass2_d = 1'b0;
          end else if (!pass2_q) begin
            pass2_d = 1'b1;
            timer_d = RINSE_LD;
`endif
          end else begin
            state_d = S_SPIN;
            timer_d = SPIN_LD;
          end
        end
      end
      S_SPIN: begin
        if (!lid) begin
          if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_REFUND: begin
        // ph_q set means a coin went back last cycle, so this one is a gap
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (ph_q) begin
          ph_d = 1'b0;
        end else begin
          ph_d     = 1'b1;
          ret_d    = 1'b1;
          credit_d = credit_q - COIN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    water_d = 1'b0;
    if (!lid) begin
      unique case (state_d)
        S_SOAK:  water_d = timer_d >= SOAK_TH;
        S_WASH:  water_d = timer_d >= WASH_TH;
        S_RINSE: water_d = timer_d >= RINSE_TH;
        default: water_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      credit_q        <= '0;
      ph_q            <= 1'b0;
      idle            <= 1'b1;
      ready           <= 1'b0;
      soak_Operation  <= 1'b0;
      wash_Operation  <= 1'b0;
      rinse_Operation <= 1'b0;
      spin_Operation  <= 1'b0;
      water_Intake    <= 1'b0;
      coin_Return     <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      credit_q        <= credit_d;
      ph_q            <= ph_d;
      idle            <= state_d == S_IDLE;
      ready           <= state_d == S_READY;
      soak_Operation  <= state_d == S_SOAK;
      wash_Operation  <= state_d == S_WASH;
      rinse_Operation <= state_d == S_RINSE;
      spin_Operation  <= state_d == S_SPIN;
      water_Intake    <= water_d;
      coin_Return     <= ret_d;
      done            <= done_d;
    end
  end

`ifdef DOUBLE_RINSE_EN
  always_ff @(posedge clock) begin
    if (reset) pass2_q <= 1'b0;
    else       pass2_q <= pass2_d;
  end
`endif

endmodule
